// File: rtl/cursor_input_ctrl_if.sv
// rtl/cursor_input_ctrl_if.sv - raw button, mode and cursor signals of cursor_input_ctrl
interface cursor_input_ctrl_if;
    logic       btn_up_n;
    logic       btn_down_n;
    logic       btn_left_n;
    logic       btn_right_n;
    logic       btn_confirm_n;
    logic       move_enable;
    logic [2:0] clamp_len;
    logic [2:0] i_actual;
    logic [2:0] j_actual;
    logic       confirm;
    logic       any_pressed;

    modport master (
        output btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_confirm_n,
        output move_enable, clamp_len,
        input  i_actual, j_actual, confirm, any_pressed
    );

    modport slave (
        input  btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_confirm_n,
        input  move_enable, clamp_len,
        output i_actual, j_actual, confirm, any_pressed
    );
endinterface

// File: rtl/cursor_input_ctrl.sv
// rtl/cursor_input_ctrl.sv - debounced 5-button board cursor with column clamp and confirm pulse
module cursor_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GRID_SIZE       = 5
) (
    input  logic               clk,
    input  logic               rst,
    cursor_input_ctrl_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] GRID = 3'(GRID_SIZE);
    localparam logic [2:0] GMAX = 3'(GRID_SIZE - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    // Bit order: 0 up, 1 down, 2 left, 3 right, 4 confirm
    logic [4:0] raw_n;
    logic [4:0] sync1_n;
    logic [4:0] sync2_n;
    logic [4:0] press_ev;
    logic [4:0] level;

    assign raw_n = {bus.btn_confirm_n, bus.btn_right_n, bus.btn_left_n,
                    bus.btn_down_n, bus.btn_up_n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_n <= '1;
            sync2_n <= '1;
        end else begin
            sync1_n <= raw_n;
            sync2_n <= sync1_n;
        end
    end

    for (genvar b = 0; b < 5; b++) begin : g_db
        db_state_t       state;
        db_state_t       state_nx;
        logic [CW-1:0]   cnt;
        logic [CW-1:0]   cnt_nx;
        logic            ev;
        logic            pressed;

        assign pressed = ~sync2_n[b];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= RELEASED;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            ev       = 1'b0;
            unique case (state)
                RELEASED: begin
                    cnt_nx = '0;
                    if (pressed) state_nx = PRESS_WAIT;
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state_nx = RELEASED;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = PRESSED;
                        cnt_nx   = '0;
                        ev       = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    cnt_nx = '0;
                    if (!pressed) state_nx = RELEASE_WAIT;
                end
                RELEASE_WAIT: begin
                    // A press sample mid-wait means the release was a bounce.
                    if (pressed) begin
                        state_nx = PRESSED;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = RELEASED;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = RELEASED;
                    cnt_nx   = '0;
                end
            endcase
        end

        assign press_ev[b] = ev;
        assign level[b]    = (state == PRESSED) || (state == RELEASE_WAIT);
    end

    logic [2:0] len_eff;
    logic [2:0] jmax;
    logic [2:0] i_r, i_nx;
    logic [2:0] j_r, j_nx;
    logic       confirm_r, confirm_nx;
    logic       vert_move;

    always_comb begin
        len_eff = bus.clamp_len;
        if (bus.clamp_len == 3'd0)   len_eff = 3'd1;
        else if (bus.clamp_len > GRID) len_eff = GRID;
    end

    assign jmax      = GRID - len_eff;
    assign vert_move = press_ev[0] | press_ev[1];

    always_comb begin
        i_nx       = i_r;
        j_nx       = j_r;
        confirm_nx = bus.move_enable & press_ev[4];

        if (bus.move_enable) begin
            if (press_ev[0])      i_nx = (i_r == 3'd0) ? GMAX : i_r - 3'd1;
            else if (press_ev[1]) i_nx = (i_r == GMAX) ? 3'd0 : i_r + 3'd1;
        end

        // Clamp wins over any horizontal move so a raised clamp_len settles in one cycle.
        if (j_r > jmax) begin
            j_nx = jmax;
        end else if (bus.move_enable && !vert_move) begin
            if (press_ev[2])      j_nx = (j_r == 3'd0) ? jmax : j_r - 3'd1;
            else if (press_ev[3]) j_nx = (j_r == jmax) ? 3'd0 : j_r + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_r       <= 3'd0;
            j_r       <= 3'd0;
            confirm_r <= 1'b0;
        end else begin
            i_r       <= i_nx;
            j_r       <= j_nx;
            confirm_r <= confirm_nx;
        end
    end

    assign bus.i_actual    = i_r;
    assign bus.j_actual    = j_r;
    assign bus.confirm     = confirm_r;
    assign bus.any_pressed = |level;
endmodule
